// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority with starvation guard.
module alu_share_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [2:0]        req0_funct3,
  input  logic [1:0]        req0_aluop,
  input  logic              req0_inst30,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [2:0]        req1_funct3,
  input  logic [1:0]        req1_aluop,
  input  logic              req1_inst30,

  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [2:0]        alu_funct3,
  output logic [1:0]        alu_aluop,
  output logic              alu_inst30,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_branch,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_branch,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_branch,

  output logic [1:0]        grant_id
);

  logic              elig0, elig1;
  logic              gnt0, gnt1;

  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_result_q, rsp1_result_q;
  logic              rsp0_branch_q, rsp1_branch_q;

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;
`else
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  logic [2:0] starve_q, starve_d;
`endif

  // A slot is free if empty or being drained this cycle.
  always_comb begin
    elig0 = !rst && req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = !rst && req1_valid && (!rsp1_valid_q || rsp1_ready);
`ifdef ALU_ARB_RR_EN
    gnt1  = elig1 && (!elig0 || ptr_q);
`else
    gnt1  = elig1 && (!elig0 || (starve_q == SMAX));
`endif
    gnt0  = elig0 && !gnt1;
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt0)
      ptr_d = 1'b1;
    else if (gnt1)
      ptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= 1'b0;
    else
      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    starve_d = 3'd0;
    if (elig1 && !gnt1)
      starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_q <= 3'd0;
    else
      starve_q <= starve_d;
  end
`endif

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_funct3 = 3'd0;
    alu_aluop  = 2'd0;
    alu_inst30 = 1'b0;
    unique case (1'b1)
      gnt0: begin
        alu_op1    = req0_op1;
        alu_op2    = req0_op2;
        alu_funct3 = req0_funct3;
        alu_aluop  = req0_aluop;
        alu_inst30 = req0_inst30;
      end
      gnt1: begin
        alu_op1    = req1_op1;
        alu_op2    = req1_op2;
        alu_funct3 = req1_funct3;
        alu_aluop  = req1_aluop;
        alu_inst30 = req1_inst30;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_branch_q <= 1'b0;
    end else if (gnt0) begin
      rsp0_valid_q  <= 1'b1;
      rsp0_result_q <= alu_result;
      rsp0_branch_q <= alu_branch;
    end else if (rsp0_ready) begin
      rsp0_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_branch_q <= 1'b0;
    end else if (gnt1) begin
      rsp1_valid_q  <= 1'b1;
      rsp1_result_q <= alu_result;
      rsp1_branch_q <= alu_branch;
    end else if (rsp1_ready) begin
      rsp1_valid_q  <= 1'b0;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign grant_id    = {gnt1, gnt0};

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_branch = rsp0_branch_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_branch = rsp1_branch_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, scoreboard and corner sequences.
// Build with ALU_ARB_RR_EN to check the round-robin variant.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  logic         req0_valid, req0_ready, req0_inst30;
  logic [W-1:0] req0_op1, req0_op2;
  logic [2:0]   req0_funct3;
  logic [1:0]   req0_aluop;
  logic         req1_valid, req1_ready, req1_inst30;
  logic [W-1:0] req1_op1, req1_op2;
  logic [2:0]   req1_funct3;
  logic [1:0]   req1_aluop;

  logic [W-1:0] alu_op1, alu_op2, alu_result;
  logic [2:0]   alu_funct3;
  logic [1:0]   alu_aluop;
  logic         alu_inst30, alu_branch;

  logic         rsp0_valid, rsp0_ready, rsp0_branch;
  logic [W-1:0] rsp0_result;
  logic         rsp1_valid, rsp1_ready, rsp1_branch;
  logic [W-1:0] rsp1_result;
  logic [1:0]   grant_id;

  int n_chk = 0;
  int n_fail = 0;

  alu_share_arbiter #(.DATA_W(W), .STARVE_MAX(7)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_funct3(req0_funct3), .req0_aluop(req0_aluop),
    .req0_inst30(req0_inst30),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_funct3(req1_funct3), .req1_aluop(req1_aluop),
    .req1_inst30(req1_inst30),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_funct3(alu_funct3), .alu_aluop(alu_aluop),
    .alu_inst30(alu_inst30),
    .alu_result(alu_result), .alu_branch(alu_branch),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_branch(rsp0_branch),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_branch(rsp1_branch),
    .grant_id(grant_id)
  );

  initial forever #5 clk = ~clk;

  // Stand-in for the shared ALU: {branch, result}
  function automatic logic [W:0] alu_f(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic [2:0] f3,
                                       input logic [1:0] op,
                                       input logic i30);
    logic [W-1:0] r;
    logic br;
    r  = a + b;
    br = 1'b0;
    case (op)
      2'b01: begin
        case (f3)
          3'd0: br = (a == b);
          3'd1: br = (a != b);
          3'd4: br = ($signed(a) < $signed(b));
          3'd5: br = ($signed(a) >= $signed(b));
          3'd6: br = (a < b);
          3'd7: br = (a >= b);
          default: br = 1'b0;
        endcase
      end
      2'b10, 2'b11: begin
        case (f3)
          3'd0: r = i30 ? a - b : a + b;
          3'd1: r = a << b[4:0];
          3'd2: r = W'($signed(a) < $signed(b));
          3'd3: r = W'(a < b);
          3'd4: r = a ^ b;
          3'd5: r = i30 ? W'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
      default: ;
    endcase
    return {br, r};
  endfunction

  assign {alu_branch, alu_result} =
    alu_f(alu_op1, alu_op2, alu_funct3, alu_aluop, alu_inst30);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accepted request, pop on consumed response.
  logic [W:0] q0[$];
  logic [W:0] q1[$];

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb0_unexpected: actual rsp %0h required none",
                   rsp0_result);
        end else begin
          chk("sb0_data", 64'({rsp0_branch, rsp0_result}),
              64'(q0.pop_front()));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb1_unexpected: actual rsp %0h required none",
                   rsp1_result);
        end else begin
          chk("sb1_data", 64'({rsp1_branch, rsp1_result}),
              64'(q1.pop_front()));
        end
      end
      if (req0_ready)
        q0.push_back(alu_f(req0_op1, req0_op2, req0_funct3,
                           req0_aluop, req0_inst30));
      if (req1_ready)
        q1.push_back(alu_f(req1_op1, req1_op2, req1_funct3,
                           req1_aluop, req1_inst30));
    end
  end

  typedef struct {
    logic         id;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0]   f3;
    logic [1:0]   aluop;
    logic         i30;
    logic [W-1:0] res;
    logic         br;
  } vec_t;

  vec_t vecs[9];

  task automatic drive_vec(input vec_t v);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_op1 = v.op1; req0_op2 = v.op2;
      req0_funct3 = v.f3; req0_aluop = v.aluop; req0_inst30 = v.i30;
    end else begin
      req1_valid = 1'b1; req1_op1 = v.op1; req1_op2 = v.op2;
      req1_funct3 = v.f3; req1_aluop = v.aluop; req1_inst30 = v.i30;
    end
  endtask

  // Simple add request with op1 == op2 == a
  task automatic set_req(input int id, input logic [W-1:0] a);
    vec_t v;
    v = '{id[0], a, a, 3'd0, 2'd0, 1'b0, '0, 1'b0};
    drive_vec(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]   prev;
    logic         v_valid, v_br;
    logic [W-1:0] v_res;

    vecs[0] = '{1'b0, 32'd5, 32'd7, 3'd0, 2'd2, 1'b0, 32'd12, 1'b0};
    vecs[1] = '{1'b1, 32'h10, 32'h10, 3'd0, 2'd1, 1'b0, 32'h20, 1'b1};
    vecs[2] = '{1'b0, 32'd10, 32'd3, 3'd0, 2'd2, 1'b1, 32'd7, 1'b0};
    vecs[3] = '{1'b1, 32'hF0, 32'h3C, 3'd7, 2'd2, 1'b0, 32'h30, 1'b0};
    vecs[4] = '{1'b0, 32'hF0, 32'h0F, 3'd6, 2'd2, 1'b0, 32'hFF, 1'b0};
    vecs[5] = '{1'b1, 32'd1, 32'd4, 3'd1, 2'd2, 1'b0, 32'd16, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'd0, 2'd0, 1'b0, 32'd0, 1'b0};
    vecs[7] = '{1'b1, 32'd3, 32'd5, 3'd1, 2'd1, 1'b0, 32'd8, 1'b1};
    vecs[8] = '{1'b0, 32'd3, 32'd3, 3'd1, 2'd1, 1'b0, 32'd6, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2;
    req0_funct3 = 3'd0; req0_aluop = 2'd0; req0_inst30 = 1'b0;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0;
    req1_funct3 = 3'd0; req1_aluop = 2'd0; req1_inst30 = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    @(negedge clk);
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("rst_rsp0_result", 64'(rsp0_result), 64'd0);
    chk("rst_rsp1_result", 64'(rsp1_result), 64'd0);
    chk("rst_rsp_branch", 64'({rsp1_branch, rsp0_branch}), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);

    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("idle_grant", 64'(grant_id), 64'd0);
    chk("idle_alu_ops", 64'({alu_op1, alu_op2}), 64'd0);
    chk("idle_alu_ctl", 64'({alu_funct3, alu_aluop, alu_inst30}), 64'd0);

    for (int i = 0; i < 9; i++) begin
      tick();
      drive_vec(vecs[i]);
      @(negedge clk);
      chk("vec_grant", 64'(grant_id), vecs[i].id ? 64'd2 : 64'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      v_valid = vecs[i].id ? rsp1_valid : rsp0_valid;
      v_res   = vecs[i].id ? rsp1_result : rsp0_result;
      v_br    = vecs[i].id ? rsp1_branch : rsp0_branch;
      chk("vec_valid", 64'(v_valid), 64'd1);
      chk("vec_result", 64'(v_res), 64'(vecs[i].res));
      chk("vec_branch", 64'(v_br), 64'(vecs[i].br));
    end

    // Contention with both consumers always ready
    tick();
    set_req(0, 32'd1);
    set_req(1, 32'd3);
    prev = 2'b00;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
`ifdef ALU_ARB_RR_EN
      if (k == 0)
        chk("rr_first", 64'(grant_id[0] ^ grant_id[1]), 64'd1);
      else
        chk("rr_alt", 64'(grant_id), 64'(~prev));
`else
      chk("starve_seq", 64'(grant_id), (k % 8 == 7) ? 64'd2 : 64'd1);
`endif
      prev = grant_id;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

    // Backpressure and both-full
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req(0, 32'd1);
    @(negedge clk);
    chk("bp_a_grant", 64'(grant_id), 64'd1);
    tick();
    set_req(0, 32'd2);
    set_req(1, 32'd5);
    @(negedge clk);
    chk("bp_b_grant", 64'(grant_id), 64'd2);
    chk("bp_b_req0_ready", 64'(req0_ready), 64'd0);
    chk("bp_b_rsp0", 64'({rsp0_valid, rsp0_result}), 64'({1'b1, 32'd2}));
    tick();
    set_req(1, 32'd6);
    @(negedge clk);
    chk("bp_full_grant", 64'(grant_id), 64'd0);
    chk("bp_full_rsp0", 64'(rsp0_result), 64'd2);
    chk("bp_full_rsp1", 64'(rsp1_result), 64'd10);
    tick();
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("b2b_grant", 64'(grant_id), 64'd1);
    tick();
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("b2b_rsp0", 64'({rsp0_valid, rsp0_result}), 64'({1'b1, 32'd4}));
    chk("b2b_grant1", 64'(grant_id), 64'd2);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("drain_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("drain_rsp1", 64'({rsp1_valid, rsp1_result}), 64'({1'b1, 32'd12}));
    tick();
    @(negedge clk);
    chk("drain_rsp1_valid", 64'(rsp1_valid), 64'd0);

    // Reset one cycle after a grant
    tick();
    set_req(0, 32'd9);
    @(negedge clk);
    chk("mid_grant", 64'(grant_id), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp0", 64'({rsp0_valid, rsp0_result}), 64'd0);
    chk("mid_rst_ready", 64'({req1_ready, req0_ready, grant_id}), 64'd0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    tick();
    @(negedge clk);
    chk("post_rst_valid2", 64'({rsp1_valid, rsp0_valid}), 64'd0);

    chk("sb_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: req0 is the execute stage and req1 is an address/branch helper.
- Each cycle, at most one request is granted. Its operands and controls are driven onto the ALU, and `alu_result`/`alu_branch` are captured into that requester's response register.
- Valid/ready handshakes on both the request and response sides.
- Sits between the execute-stage control and the ALU instance. The ALU is tied with `aluinputpc=0` and `alusrc=0`; the arbiter supplies final operands.

Parameters:
- DATA_W, 32, operand/result width (matches REG_DATA_WIDTH)
- STARVE_MAX, 7, consecutive losses after which the losing requester is forced to win (fixed-priority mode only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request N (N=0,1) presents an operation
- reqN_ready  out  1  request N accepted this cycle
- reqN_op1  in  DATA_W  operand 1
- reqN_op2  in  DATA_W  operand 2
- reqN_funct3  in  3  ALU funct3
- reqN_aluop  in  2  ALU aluop
- reqN_inst30  in  1  ALU inst30
- alu_op1, alu_op2  out  DATA_W  to shared ALU operands
- alu_funct3  out  3  to ALU
- alu_aluop  out  2  to ALU
- alu_inst30  out  1  to ALU
- alu_result  in  DATA_W  from ALU
- alu_branch  in  1  from ALU
- rspN_valid  out  1  response N holds a result
- rspN_ready  in  1  consumer N takes the result
- rspN_result  out  DATA_W  registered result
- rspN_branch  out  1  registered branch flag
- grant_id  out  2  00 none, 01 req0, 10 req1 (combinational, this cycle)

Behaviour:
- Reset values (async on `rst`): `rspN_valid=0`, `rspN_result=0`, `rspN_branch=0`, starvation counter=0, rr pointer=0.
  - During reset: `reqN_ready=0`, `grant_id=00`.
- Eligibility: requester N is eligible when `reqN_valid` is high and its response slot is free (`rspN_valid==0` or `rspN_ready==1` this cycle). Ineligible requesters never get `reqN_ready`.
- Arbitration, fixed priority: req0 wins whenever eligible.
  - A 3-bit starvation counter increments each cycle req1 is eligible but loses. It clears when req1 is granted or req1 is not eligible.
  - When the counter equals STARVE_MAX and req1 is eligible, req1 wins.
- Grant drives the ALU mux:
  - `alu_*` take the granted requester's fields.
  - With no grant, `alu_*` are driven to 0 (`aluop=00`, giving add 0+0).
- `reqN_ready` equals the grant for N (single cycle). A requester holds valid and fields stable until ready.
- Latency: 1 cycle. On the clock edge after a grant, `rspN_result<=alu_result`, `rspN_branch<=alu_branch` and `rspN_valid<=1`.
- Response register:
  - Holds its value while `rspN_valid && !rspN_ready`.
  - On `rspN_ready` with no new grant for N, `rspN_valid<=0` and the data is held.
  - Simultaneous `rspN_ready` and a new grant for N: back-to-back; valid stays 1 and data updates. This gives one result per cycle of throughput per requester.
- Both responses full with neither consumer ready: no grants, `grant_id=00`.
- Only one requester eligible: it is granted regardless of priority and pointer.
- `rst` asserted mid-operation: any pending response is discarded, the starvation counter and pointer are cleared, and nothing is captured on the reset edge.
- Results are passed through unmodified (no width change). The ALU's own alignment/branch semantics apply.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined:
  - Round-robin arbitration with a 1-bit pointer naming the preferred requester.
  - When both are eligible, the preferred requester wins and the pointer flips to the other. A single eligible grant also sets the pointer to the other requester.
  - The starvation counter and STARVE_MAX are unused; the counter is held at 0.
- Undefined: fixed priority with starvation counter, as described above.

Test Plan:
- Single req0, ADD: op1=5, op2=7, funct3=000, aluop=10, inst30=0, rsp0_ready=1 -> `req0_ready=1` and `grant_id=01` same cycle; next cycle `rsp0_valid=1`, `rsp0_result=12`, `rsp0_branch=0`.
- Branch on req1: aluop=01, funct3=000, op1=op2=32'h10, both operands 32'h10 -> `rsp1_result=32'h20`, `rsp1_branch=1`.
- Contention, fixed mode: both valid continuously, both rsp_ready=1 -> req0 granted 7 consecutive cycles, req1 granted on the 8th, then the counter resets to 0.
- Contention with ALU_ARB_RR_EN: both valid continuously -> `grant_id` alternates 01,10,01,10.
- Backpressure: rsp0_ready=0 after one result -> `req0_ready=0`, `rsp0_result` stable; a pending req1 is granted meanwhile. Raising rsp0_ready and req0_valid together yields back-to-back capture with `rsp0_valid` staying 1.
- Reset mid-flight: `rst=1` one cycle after a grant -> `rsp0_valid=0`, `rsp0_result=0` immediately (asynchronous); no stale response after release.
